// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit (IFU_TIMEOUT_EN optional)
package ifu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } ifu_state_t;

    localparam logic [15:0] RESET_PC      = 16'h0000;
    localparam int          TIMEOUT_LIMIT = 255;
    localparam int          TMO_CNT_W     = 8;
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_LIMIT - 1);

    localparam int IR_F1_HI  = 15;
    localparam int IR_F1_LO  = 12;
    localparam int IR_F2_HI  = 11;
    localparam int IR_F2_LO  = 10;
    localparam int IR_F3_HI  = 9;
    localparam int IR_F3_LO  = 8;
    localparam int IR_OFF_HI = 7;
    localparam int IR_OFF_LO = 0;

    function automatic logic [15:0] sext_off(input logic [7:0] off);
        return {{8{off[7]}}, off};
    endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// rtl/ifu_next_pc.sv - next-PC select: return target, relative branch or sequential, all modulo 2^16
module ifu_next_pc
    import ifu_pkg::*;
(
    input  logic [15:0] pc,
    input  logic [7:0]  offset,
    input  logic        branch,
    input  logic        muxreturn,
    input  logic [15:0] ret_addr,
    output logic [15:0] next_pc
);

    logic [15:0] pc_inc;

    assign pc_inc = pc + 16'd1;

    // Return outranks branch when both are signalled on the same edge.
    always_comb begin
        next_pc = pc_inc;
        if (muxreturn) begin
            next_pc = ret_addr;
        end else if (branch) begin
            next_pc = pc_inc + sext_off(offset);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch FSM, IR and PC; IFU_TIMEOUT_EN enables the WAIT timeout / fetch_err path
module instr_fetch_unit
    import ifu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [3:0]  ir_1,
    output logic [1:0]  ir_2,
    output logic [1:0]  ir_3,
    output logic        ir_valid,
    input  logic        exec_done,
    input  logic        branch,
    input  logic        muxreturn,
    input  logic [15:0] ret_addr,
    output logic [15:0] pc,
    output logic        fetch_err
);

    ifu_state_t  state_q, state_d;
    logic [15:0] pc_q;
    logic [15:0] ir_q;
    logic [15:0] next_pc;
    logic        ir_load;
    logic        pc_load;
    logic        req_block;
    logic        req_active;

`ifdef IFU_TIMEOUT_EN
    logic                 err_q;
    logic [TMO_CNT_W-1:0] tmo_cnt;
    logic                 tmo_hit;

    assign tmo_hit   = (state_q == WAIT) && !imem_ack && (tmo_cnt == TMO_LAST);
    assign req_block = err_q;
    assign fetch_err = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (state_q == WAIT && state_d == WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
        end
    end
`else
    assign req_block = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // The request is also gated by reset so an abandoned fetch cannot be acked into IR.
    assign req_active = (state_q == FETCH || state_q == WAIT) && !reset && !req_block;

    always_comb begin
        state_d = state_q;
        ir_load = 1'b0;
        pc_load = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (req_active) begin
                    if (imem_ack) begin
                        state_d = HOLD;
                        ir_load = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    state_d = HOLD;
                    ir_load = 1'b1;
                end
`ifdef IFU_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = FETCH;
                end
`endif
            end
            HOLD: begin
                if (exec_done) begin
                    state_d = FETCH;
                    pc_load = 1'b1;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (ir_load) begin
                ir_q <= imem_data;
            end
            if (pc_load) begin
                pc_q <= next_pc;
            end
        end
    end

    ifu_next_pc u_next_pc (
        .pc        (pc_q),
        .offset    (ir_q[IR_OFF_HI:IR_OFF_LO]),
        .branch    (branch),
        .muxreturn (muxreturn),
        .ret_addr  (ret_addr),
        .next_pc   (next_pc)
    );

    assign imem_req  = req_active;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir_valid  = (state_q == HOLD);
    assign ir_1      = ir_q[IR_F1_HI:IR_F1_LO];
    assign ir_2      = ir_q[IR_F2_HI:IR_F2_LO];
    assign ir_3      = ir_q[IR_F3_HI:IR_F3_LO];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit (IFU_TIMEOUT_EN selects timeout checks)
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [3:0]  ir_1;
    logic [1:0]  ir_2;
    logic [1:0]  ir_3;
    logic        ir_valid;
    logic        exec_done;
    logic        branch;
    logic        muxreturn;
    logic [15:0] ret_addr;
    logic [15:0] pc;
    logic        fetch_err;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .ir_1      (ir_1),
        .ir_2      (ir_2),
        .ir_3      (ir_3),
        .ir_valid  (ir_valid),
        .exec_done (exec_done),
        .branch    (branch),
        .muxreturn (muxreturn),
        .ret_addr  (ret_addr),
        .pc        (pc),
        .fetch_err (fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Answer one fetch after 'waits' unacked request cycles; noise drives control inputs meanwhile.
    task automatic mem_serve(input int waits, input logic [15:0] data, input logic [15:0] addr, input logic noise);
        int k = 0;
        while (!imem_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_seen", imem_req, 1);
        for (int i = 0; i < waits; i++) begin
            imem_ack  = 1'b0;
            exec_done = noise;
            branch    = noise;
            muxreturn = noise;
            check("addr_wait", imem_addr, addr);
            check("req_wait", imem_req, 1);
            @(negedge clk);
        end
        exec_done = 1'b0;
        branch    = 1'b0;
        muxreturn = 1'b0;
        check("addr_ack", imem_addr, addr);
        check("req_ack", imem_req, 1);
        imem_ack  = 1'b1;
        imem_data = data;
        exp_q.push_back(data);
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        check("pc_after_fetch", pc, addr);
    endtask

    task automatic check_ir();
        int k = 0;
        logic [15:0] e;
        while (!ir_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ir_valid", ir_valid, 1);
        check("sb_level", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ir_1", ir_1, e[15:12]);
            check("ir_2", ir_2, e[11:10]);
            check("ir_3", ir_3, e[9:8]);
        end
        check("req_hold", imem_req, 0);
    endtask

    task automatic exec(input logic br, input logic mr, input logic [15:0] ra, input logic [15:0] exp_pc);
        exec_done = 1'b1;
        branch    = br;
        muxreturn = mr;
        ret_addr  = ra;
        @(negedge clk);
        exec_done = 1'b0;
        branch    = 1'b0;
        muxreturn = 1'b0;
        ret_addr  = 16'($urandom);
        check("pc_next", pc, exp_pc);
        check("addr_next", imem_addr, exp_pc);
        check("valid_drop", ir_valid, 0);
        check("req_refetch", imem_req, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int hi;
        int bad;
        reset     = 1'b1;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        exec_done = 1'b0;
        branch    = 1'b0;
        muxreturn = 1'b0;
        ret_addr  = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_pc", pc, 16'h0000);
        check("rst_valid", ir_valid, 0);
        check("rst_err", fetch_err, 0);
        check("rst_ir", {ir_1, ir_2, ir_3}, 0);

        reset = 1'b0;
        #1;
        check("req_after_rst", imem_req, 1);
        check("addr_after_rst", imem_addr, 16'h0000);

        mem_serve(2, 16'hF400, 16'h0000, 1'b0);
        check_ir();
        imem_ack  = 1'b1;
        imem_data = 16'hDEAD;
        @(negedge clk);
        imem_ack  = 1'b0;
        check("hold_ign_ack_ir1", ir_1, 4'hF);
        check("hold_ign_ack_ir2", ir_2, 2'b01);
        check("hold_ign_ack_valid", ir_valid, 1);
        exec(1'b0, 1'b0, 16'h5555, 16'h0001);

        mem_serve(0, 16'h12FE, 16'h0001, 1'b0);
        check_ir();
        exec(1'b0, 1'b1, 16'h0010, 16'h0010);

        mem_serve(1, 16'h03FE, 16'h0010, 1'b1);
        check_ir();
        exec(1'b1, 1'b0, 16'hAAAA, 16'h000F);

        mem_serve(0, 16'h6005, 16'h000F, 1'b0);
        check_ir();
        exec(1'b1, 1'b1, 16'h1234, 16'h1234);

        mem_serve(3, 16'h9C00, 16'h1234, 1'b1);
        check_ir();
        exec(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);

        mem_serve(0, 16'hA77F, 16'hFFFF, 1'b0);
        check_ir();
        exec(1'b0, 1'b0, 16'h4321, 16'h0000);

        mem_serve(0, 16'hC97F, 16'h0000, 1'b0);
        check_ir();
        exec(1'b1, 1'b0, 16'h7777, 16'h0080);

        // Reset while the fetch at 0x0080 is outstanding, with a late ack during reset.
        @(negedge clk);
        @(negedge clk);
        check("wait_req", imem_req, 1);
        reset     = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 16'hBEEF;
        #1;
        check("rst_mid_req", imem_req, 0);
        @(negedge clk);
        check("rst_mid_req2", imem_req, 0);
        check("rst_mid_valid", ir_valid, 0);
        @(negedge clk);
        reset    = 1'b0;
        imem_ack = 1'b0;
        #1;
        check("rst_mid_ir", {ir_1, ir_2, ir_3}, 0);
        check("rst_mid_valid2", ir_valid, 0);
        check("rst_mid_addr", imem_addr, 16'h0000);
        check("rst_mid_restart", imem_req, 1);
        @(negedge clk);
        mem_serve(0, 16'h5A00, 16'h0000, 1'b0);
        check_ir();
        exec(1'b0, 1'b0, 16'h1111, 16'h0001);

        hi  = 0;
        bad = 0;
`ifdef IFU_TIMEOUT_EN
        while (imem_req && hi < 400) begin
            if (fetch_err || imem_addr != 16'h0001) bad++;
            @(negedge clk);
            hi++;
        end
        check("tmo_req_cycles", hi, 256);
        check("tmo_early_err", bad, 0);
        check("tmo_err_pulse", fetch_err, 1);
        check("tmo_req_low", imem_req, 0);
        @(negedge clk);
        check("tmo_err_clear", fetch_err, 0);
        check("tmo_rereq", imem_req, 1);
        check("tmo_readdr", imem_addr, 16'h0001);
`else
        while (hi < 300) begin
            if (!imem_req || fetch_err || imem_addr != 16'h0001) bad++;
            @(negedge clk);
            hi++;
        end
        check("no_tmo_stall", bad, 0);
`endif
        mem_serve(0, 16'h3C00, 16'h0001, 1'b0);
        check_ir();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
